// File: rtl/usb_rx_pkg.sv
// Shared types for the USB receive path: decoded line states and EOP qualifier states.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        LS_SE0,
        LS_J,
        LS_K,
        LS_SE1
    } line_state_t;

    typedef enum logic [1:0] {
        IDLE,
        SE0_CNT,
        WAIT_J,
        RESET_HOLD
    } eop_state_t;

endpackage

// File: rtl/usb_line_decode.sv
// Maps the synchronised D+/D- pair onto a symbolic line state; shared with the NRZI decoder.
module usb_line_decode
    import usb_rx_pkg::*;
(
    input  logic        d_plus,
    input  logic        d_minus,
    output line_state_t line_state
);

    always_comb begin
        unique case ({d_plus, d_minus})
            2'b00:   line_state = LS_SE0;
            2'b10:   line_state = LS_J;
            2'b01:   line_state = LS_K;
            default: line_state = LS_SE1;
        endcase
    end

endmodule

// File: rtl/eop_qualifier.sv
// Sequential EOP qualifier: counts SE0 bit-times on each shift_enable strobe and reports
// a valid EOP, a malformed EOP, or a bus reset, all from registered outputs.
module eop_qualifier
    import usb_rx_pkg::*;
#(
    parameter int SE0_MIN_BITS = 2,
    parameter int J_MIN_BITS   = 1,
    parameter int RESET_BITS   = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic shift_enable,
    output logic se0_active,
    output logic eop_strobe,
    output logic eop_error,
    output logic bus_reset
);

    localparam int CW = $clog2(RESET_BITS + 1);
    localparam int JW = $clog2(J_MIN_BITS + 1);
    localparam logic [CW-1:0] RESET_CNT   = CW'(RESET_BITS);
    localparam logic [CW-1:0] SE0_MIN_CNT = CW'(SE0_MIN_BITS);
    localparam logic [JW-1:0] J_MIN_CNT   = JW'(J_MIN_BITS);

    line_state_t   line_state;
    eop_state_t    state_q, state_d;
    logic [CW-1:0] se0_cnt_q, se0_cnt_d, se0_inc;
    logic [JW-1:0] j_cnt_q, j_cnt_d, j_inc;
    logic          se0_active_q, se0_active_d;
    logic          eop_strobe_q, eop_strobe_d;
    logic          eop_error_q, eop_error_d;
    logic          bus_reset_q, bus_reset_d;

    usb_line_decode u_line_decode (
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .line_state (line_state)
    );

    assign se0_inc = se0_cnt_q + 1'b1;
    assign j_inc   = j_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            se0_cnt_q    <= '0;
            j_cnt_q      <= '0;
            se0_active_q <= 1'b0;
            eop_strobe_q <= 1'b0;
            eop_error_q  <= 1'b0;
            bus_reset_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            se0_cnt_q    <= se0_cnt_d;
            j_cnt_q      <= j_cnt_d;
            se0_active_q <= se0_active_d;
            eop_strobe_q <= eop_strobe_d;
            eop_error_q  <= eop_error_d;
            bus_reset_q  <= bus_reset_d;
        end
    end

    // Pulses default low so they last exactly one clk; levels and counters hold between strobes.
    always_comb begin
        state_d      = state_q;
        se0_cnt_d    = se0_cnt_q;
        j_cnt_d      = j_cnt_q;
        se0_active_d = se0_active_q;
        eop_strobe_d = 1'b0;
        eop_error_d  = 1'b0;
        bus_reset_d  = bus_reset_q;

        if (shift_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (line_state == LS_SE0) begin
                        state_d      = SE0_CNT;
                        se0_cnt_d    = CW'(1);
                        se0_active_d = 1'b1;
                    end
                end
                SE0_CNT: begin
                    if (line_state == LS_SE0) begin
                        se0_cnt_d = se0_inc;
                        if (se0_inc == RESET_CNT) begin
                            state_d     = RESET_HOLD;
                            bus_reset_d = 1'b1;
                        end
                    end else begin
                        se0_cnt_d    = '0;
                        se0_active_d = 1'b0;
                        state_d      = IDLE;
                        if (line_state == LS_J && se0_cnt_q >= SE0_MIN_CNT) begin
                            if (J_MIN_BITS == 1) begin
                                eop_strobe_d = 1'b1;
                            end else begin
                                state_d = WAIT_J;
                                j_cnt_d = JW'(1);
                            end
                        end else begin
                            eop_error_d = 1'b1;
                        end
                    end
                end
                WAIT_J: begin
                    if (line_state == LS_J) begin
                        j_cnt_d = j_inc;
                        if (j_inc == J_MIN_CNT) begin
                            eop_strobe_d = 1'b1;
                            j_cnt_d      = '0;
                            state_d      = IDLE;
                        end
                    end else begin
                        eop_error_d = 1'b1;
                        j_cnt_d     = '0;
                        state_d     = IDLE;
                    end
                end
                RESET_HOLD: begin
                    if (line_state != LS_SE0) begin
                        bus_reset_d  = 1'b0;
                        se0_active_d = 1'b0;
                        se0_cnt_d    = '0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign se0_active = se0_active_q;
    assign eop_strobe = eop_strobe_q;
    assign eop_error  = eop_error_q;
    assign bus_reset  = bus_reset_q;

endmodule
